// File: rtl/serial_add_sub_word.sv
// Digit-serial two's-complement adder/subtractor, LSD first, framed in WORD_DIGITS digits.
// Latency: 1 cycle from an accepted digit to its result digit on out_sum.
// Backpressure: none; every in_valid digit without in_abort is consumed. Optional parallel
// result port enabled by defining SERIAL_ADD_SUB_PAR_OUT_EN.
module serial_add_sub_word #(
    parameter int DIGIT_W     = 1,
    parameter int WORD_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] in_a,
    input  logic [DIGIT_W-1:0] in_b,
    input  logic               in_sub,
    input  logic               in_abort,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] out_sum,
    output logic               out_last,
    output logic               out_carry,
    output logic               out_ovf
`ifdef SERIAL_ADD_SUB_PAR_OUT_EN
    ,
    output logic [DIGIT_W*WORD_DIGITS-1:0] out_word,
    output logic                           out_word_valid
`endif
);

    localparam int WORD_W = DIGIT_W * WORD_DIGITS;
    // Keep the index at least one bit wide so WORD_DIGITS==1 still elaborates.
    localparam int IDX_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_DIGITS - 1);

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic               out_valid_q, out_valid_d;
    logic [DIGIT_W-1:0] out_sum_q, out_sum_d;
    logic               out_last_q, out_last_d;
    logic               out_carry_q, out_carry_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accepted;
    logic               first;
    logic               is_last;
    logic               mode;
    logic [DIGIT_W-1:0] b_x;
    logic [DIGIT_W-1:0] s;
    logic [DIGIT_W:0]   c;

    // Ripple-carry digit adder; mode and carry-in come from in_sub on the first digit of a frame.
    always_comb begin
        accepted = in_valid & ~in_abort;
        first    = (idx_q == '0);
        is_last  = (idx_q == LAST_IDX);
        mode     = first ? in_sub : sub_q;
        c        = '0;
        s        = '0;
        b_x      = in_b ^ {DIGIT_W{mode}};
        c[0]     = first ? in_sub : carry_q;
        for (int i = 0; i < DIGIT_W; i++) begin
            s[i]   = in_a[i] ^ b_x[i] ^ c[i];
            c[i+1] = (in_a[i] & b_x[i]) | (in_a[i] & c[i]) | (b_x[i] & c[i]);
        end
    end

    // Frame position, carry chain and mode latch; abort restarts the frame.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        if (in_abort) begin
            idx_d   = '0;
            carry_d = 1'b0;
        end else if (accepted) begin
            // Carry never survives the frame boundary.
            carry_d = is_last ? 1'b0 : c[DIGIT_W];
            if (first) begin
                sub_d = in_sub;
            end
            idx_d = is_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Registered result digit and end-of-frame flags.
    always_comb begin
        out_valid_d = accepted;
        out_sum_d   = accepted ? s : out_sum_q;
        out_last_d  = accepted & is_last;
        out_carry_d = out_last_d & c[DIGIT_W];
        // Signed overflow: carry into the MSB differs from carry out of it.
        out_ovf_d   = out_last_d & (c[DIGIT_W-1] ^ c[DIGIT_W]);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;

`ifdef SERIAL_ADD_SUB_PAR_OUT_EN
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic              out_word_valid_q, out_word_valid_d;
    logic [WORD_W-1:0] full_word;

    if (WORD_DIGITS == 1) begin : g_single
        assign full_word = s;
    end else begin : g_shift
        // Holds the WORD_DIGITS-1 digits already produced; new digits enter at the top.
        logic [WORD_W-DIGIT_W-1:0] sr_q, sr_d;

        assign full_word = {s, sr_q};

        // Shift in each accepted digit; abort drops the partial word.
        always_comb begin
            sr_d = sr_q;
            if (in_abort) begin
                sr_d = '0;
            end else if (accepted) begin
                sr_d = full_word[WORD_W-1:DIGIT_W];
            end
        end

        // Assembly register.
        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end
    end

    // Capture the completed word alongside the last digit and hold it until the next one.
    always_comb begin
        out_word_valid_d = out_last_d;
        out_word_d       = out_last_d ? full_word : out_word_q;
    end

    // Parallel result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_word_q       <= '0;
            out_word_valid_q <= 1'b0;
        end else begin
            out_word_q       <= out_word_d;
            out_word_valid_q <= out_word_valid_d;
        end
    end

    assign out_word       = out_word_q;
    assign out_word_valid = out_word_valid_q;
`endif

endmodule
